tans_recoder_p: RTL and testbench
=================================

# tans_recoder_p

Parametrised tANS encoding stage for the Huffman-to-tANS recoder path. It takes one decoded symbol per cycle over a valid/ready handshake and updates the tANS state from run-time programmable tables. Per symbol it emits the renormalisation bits and their count, and on flush it reports the final state. It replaces fixed-table, fixed-size recoding with configurable alphabet size and table log, back-pressure, and error reporting.

## Interface
- SYM_W, 2, symbol width; alphabet size NS = 2^SYM_W
- R, 3, table log; L = 2^R; state range [L, 2L), state width R+1
- AW, max(SYM_W,R), config address width (derived, not overridable)
- NW, $clog2(R+1), bit-count width (derived)

- PHI  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- CFG_WE  in  1  table write strobe; honoured only in IDLE
- CFG_SEL  in  2  00 = LS[sym] (count), 01 = ST[sym] (start offset), 10 = ENC[idx] (next state), 11 = ignored
- CFG_ADDR  in  AW  symbol or ENC index (upper bits unused where narrower)
- CFG_DATA  in  R+1  write data; ST uses [R-1:0]
- START  in  1  begin block; loads state from INIT_STATE
- INIT_STATE  in  R+1  initial state; bit R forced to 1 on load
- IN_VALID / IN_READY  in / out  1  symbol handshake
- IN_SYM  in  SYM_W  symbol
- FLUSH  in  1  end of block request
- O_VALID / O_READY  out / in  1  output handshake
- O_BITS  out  R  emitted bits, valid in [O_NB-1:0], upper bits zero
- O_NB  out  NW  number of emitted bits, 0..R
- FINAL_STATE  out  R+1  state at end of block
- FINAL_VALID  out  1  one-cycle pulse with FINAL_STATE
- BUSY  out  1  high when FSM not IDLE
- ERR  out  1  sticky; cleared by RST or START

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: table writes accepted. START moves to RUN, loads X = {1, INIT_STATE[R-1:0]} and clears ERR. IN_READY = 0.
- RUN: IN_READY = !O_VALID || O_READY. A symbol transfers when IN_VALID && IN_READY.
- Encoding of symbol s from state X, with Ls = LS[s]:
  - nb = smallest k in 0..R with (X>>k) <= 2*Ls-1.
  - O_BITS = X & ((1<<nb)-1); O_NB = nb.
  - X' = ENC[ST[s] + (X>>nb) - Ls]. Index arithmetic is R bits, wrapping.
- Ls = 0: the symbol is consumed, ERR is set, X is unchanged, and no output beat is produced.
- FLUSH in RUN: go to DRAIN. If a symbol transfers in the same cycle, it is encoded first.
- DRAIN: IN_READY = 0. Wait until O_VALID = 0, then go to DONE.
- DONE: FINAL_STATE = X, FINAL_VALID = 1 for exactly one cycle, then return to IDLE.
- START outside IDLE, CFG_WE outside IDLE, and FLUSH outside RUN are all ignored.
- Tables are storage and are not cleared by RST; contents persist across resets and blocks.
- Reset values:
  - FSM = IDLE; X = L.
  - O_VALID = 0, O_BITS = 0, O_NB = 0.
  - FINAL_STATE = 0, FINAL_VALID = 0.
  - BUSY = 0, ERR = 0, IN_READY = 0.
- RST mid-block aborts immediately. The pending output beat is discarded and no FINAL_VALID is produced.

## Timing
- Throughput: one symbol per cycle while O_READY stays high.
- Latency: a symbol accepted in cycle n appears on O_VALID/O_BITS/O_NB in cycle n+1. X' is visible to the symbol of cycle n+1.
- The output register holds while O_VALID && !O_READY. Under stall, IN_READY drops combinationally from O_READY; there is no skid buffer.
- FLUSH to FINAL_VALID: at least 2 cycles (DRAIN then DONE), extended by output stall cycles.
- A table write lands at the clock edge; a START in the next cycle sees the new contents.

## Test plan
Common config for scenarios 1-4: R=3, SYM_W=2, LS = {4,2,1,1}, ST = {0,4,6,7}, ENC[i] = 8+i.
1. Basic sequence: START with INIT_STATE=8, symbols 0,3,1,2 with O_READY=1 -> beats (O_NB,O_BITS) = (1,0), (3,0), (2,3), (3,5); states 8,15,13,14. FLUSH -> FINAL_STATE=14 with a single FINAL_VALID pulse.
2. Back-pressure: same stream with O_READY low for 3 cycles after the first beat -> IN_READY low during the stall, beat 1 held stable, no symbol lost, identical outputs and final state.
3. Zero-count error: set LS[2]=0 and send symbols 0,2,1 -> ERR=1 after symbol 2; only 2 output beats; final state as if symbol 2 were absent. The next START clears ERR.
4. Simultaneous events: FLUSH with the last symbol in the same cycle -> that symbol is encoded before DONE. START while BUSY -> ignored. CFG_WE while BUSY -> table unchanged.
5. Reset mid-block: assert RST while O_VALID=1 -> next cycle all outputs are at reset values and no FINAL_VALID. A new START re-runs scenario 1 with identical results (tables retained).
6. Wide config: SYM_W=3, R=5 with a uniform table (LS=4 for all 8 symbols), from X=32 -> every beat has O_NB=3; FINAL_STATE is checked against a reference model.

Source files
------------

// File: rtl/tans_recoder_p.sv
// tans_recoder_p
// tANS encoding stage for the Huffman-to-tANS recoder path. Takes one symbol
// per cycle, renormalises the running state X against run-time programmable
// tables (LS = symbol count, ST = start offset, ENC = next-state table), and
// emits the shifted-out bits and their count per symbol. On flush it drains
// the output register and reports the final state with a one-cycle pulse.
//
// Ports:
//   PHI, RST                 clock, synchronous active-high reset
//   CFG_WE/SEL/ADDR/DATA     table write port, honoured only while idle
//   START, INIT_STATE        begin a block, seed state (MSB forced to 1)
//   IN_VALID/IN_READY/IN_SYM symbol input handshake
//   FLUSH                    end-of-block request while running
//   O_VALID/O_READY          output beat handshake
//   O_BITS, O_NB             emitted bits (LSB-aligned) and bit count
//   FINAL_STATE/FINAL_VALID  end-of-block state and its pulse
//   BUSY, ERR                not idle; sticky zero-count symbol error
//
// state | meaning
// IDLE  | tables writable, waiting for START
// RUN   | encoding symbols
// DRAIN | flush seen, waiting for the last output beat to leave
// DONE  | FINAL_VALID pulse, back to IDLE next cycle

module tans_recoder_p #(
  parameter int SYM_W = 2,
  parameter int R     = 3,
  localparam int AW   = (SYM_W > R) ? SYM_W : R,
  localparam int NW   = $clog2(R + 1)
) (
  input  logic             PHI,
  input  logic             RST,
  input  logic             CFG_WE,
  input  logic [1:0]       CFG_SEL,
  input  logic [AW-1:0]    CFG_ADDR,
  input  logic [R:0]       CFG_DATA,
  input  logic             START,
  input  logic [R:0]       INIT_STATE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [SYM_W-1:0] IN_SYM,
  input  logic             FLUSH,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [R-1:0]     O_BITS,
  output logic [NW-1:0]    O_NB,
  output logic [R:0]       FINAL_STATE,
  output logic             FINAL_VALID,
  output logic             BUSY,
  output logic             ERR
);

  localparam int NS = 1 << SYM_W;
  localparam int L  = 1 << R;
  localparam logic [R:0] X_RESET = {1'b1, {R{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_nx;

  logic [R:0]   ls_tab  [NS];
  logic [R-1:0] st_tab  [NS];
  logic [R:0]   enc_tab [L];

  logic [R:0]    x_q;
  logic          o_valid_q;
  logic [R-1:0]  o_bits_q;
  logic [NW-1:0] o_nb_q;
  logic [R:0]    final_state_q;
  logic          final_valid_q;
  logic          err_q;

  logic          in_ready;
  logic          accept;
  logic [R:0]    ls_cur;
  logic [R-1:0]  st_cur;
  logic [R+1:0]  lim;
  logic [NW-1:0] nb;
  logic [R-1:0]  bits;
  logic [R-1:0]  idx;
  logic [R:0]    x_enc;
  logic          ls_zero;

  // Tables are plain storage: no reset, contents survive RST and blocks.
  always_ff @(posedge PHI) begin
    if (CFG_WE && state_q == S_IDLE) begin
      case (CFG_SEL)
        2'b00:   ls_tab[CFG_ADDR[SYM_W-1:0]] <= CFG_DATA;
        2'b01:   st_tab[CFG_ADDR[SYM_W-1:0]] <= CFG_DATA[R-1:0];
        2'b10:   enc_tab[CFG_ADDR[R-1:0]]    <= CFG_DATA;
        default: ;
      endcase
    end
  end

  // Encoder datapath for the symbol currently offered on IN_SYM.
  always_comb begin
    ls_cur  = ls_tab[IN_SYM];
    st_cur  = st_tab[IN_SYM];
    ls_zero = (ls_cur == '0);
    lim     = {ls_cur, 1'b0} - (R+2)'(1);
    // Scan downward so the last hit is the smallest shift that fits.
    // k = R always fits for a non-zero count because X >> R == 1.
    nb = NW'(R);
    for (int k = R; k >= 0; k--) begin
      if (({1'b0, x_q} >> k) <= lim) nb = NW'(k);
    end
    bits  = x_q[R-1:0] & ~({R{1'b1}} << nb);
    // Index arithmetic wraps at R bits.
    idx   = st_cur + R'(x_q >> nb) - ls_cur[R-1:0];
    x_enc = enc_tab[idx];
  end

  always_comb begin
    state_nx = state_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE:  if (START) state_nx = S_RUN;
      S_RUN: begin
        in_ready = !o_valid_q || O_READY;
        if (FLUSH) state_nx = S_DRAIN;
      end
      S_DRAIN: if (!o_valid_q) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign accept = IN_VALID && in_ready;

  always_ff @(posedge PHI) begin
    if (RST) begin
      state_q       <= S_IDLE;
      x_q           <= X_RESET;
      o_valid_q     <= 1'b0;
      o_bits_q      <= '0;
      o_nb_q        <= '0;
      final_state_q <= '0;
      final_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_nx;

      if (state_q == S_IDLE && START) begin
        x_q   <= {1'b1, INIT_STATE[R-1:0]};
        err_q <= 1'b0;
      end else if (accept) begin
        // A zero-count symbol is swallowed: flag it and keep X.
        if (ls_zero) err_q <= 1'b1;
        else         x_q   <= x_enc;
      end

      if (!o_valid_q || O_READY) begin
        o_valid_q <= accept && !ls_zero;
        o_bits_q  <= (accept && !ls_zero) ? bits : '0;
        o_nb_q    <= (accept && !ls_zero) ? nb   : '0;
      end

      final_valid_q <= (state_nx == S_DONE);
      if (state_nx == S_DONE) final_state_q <= x_q;
    end
  end

  assign IN_READY    = in_ready;
  assign O_VALID     = o_valid_q;
  assign O_BITS      = o_bits_q;
  assign O_NB        = o_nb_q;
  assign FINAL_STATE = final_state_q;
  assign FINAL_VALID = final_valid_q;
  assign BUSY        = (state_q != S_IDLE);
  assign ERR         = err_q;

endmodule

// File: tb/tb_tans_recoder_p.sv
// Bench for tans_recoder_p: directed scenarios with literal expectations,
// randomized blocks checked every cycle against a behavioural model, and a
// wide-configuration instance checked against a uniform-table reference.

module tb_tans_recoder_p;

  logic       clk = 0;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [2:0] cfg_addr;
  logic [3:0] cfg_data;
  logic       start;
  logic [3:0] init_state;
  logic       in_valid, in_ready;
  logic [1:0] in_sym;
  logic       flush;
  logic       o_valid, o_ready;
  logic [2:0] o_bits;
  logic [1:0] o_nb;
  logic [3:0] final_state;
  logic       final_valid, busy, err;

  logic       cfg_we6;
  logic [1:0] cfg_sel6;
  logic [4:0] cfg_addr6;
  logic [5:0] cfg_data6;
  logic       start6;
  logic [5:0] init_state6;
  logic       in_valid6, in_ready6;
  logic [2:0] in_sym6;
  logic       flush6;
  logic       o_valid6, o_ready6;
  logic [4:0] o_bits6;
  logic [2:0] o_nb6;
  logic [5:0] final_state6;
  logic       final_valid6, busy6, err6;

  always #5 clk = ~clk;

  tans_recoder_p #(.SYM_W(2), .R(3)) dut (
    .PHI(clk), .RST(rst), .CFG_WE(cfg_we), .CFG_SEL(cfg_sel),
    .CFG_ADDR(cfg_addr), .CFG_DATA(cfg_data), .START(start),
    .INIT_STATE(init_state), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_SYM(in_sym), .FLUSH(flush), .O_VALID(o_valid), .O_READY(o_ready),
    .O_BITS(o_bits), .O_NB(o_nb), .FINAL_STATE(final_state),
    .FINAL_VALID(final_valid), .BUSY(busy), .ERR(err)
  );

  tans_recoder_p #(.SYM_W(3), .R(5)) dut6 (
    .PHI(clk), .RST(rst), .CFG_WE(cfg_we6), .CFG_SEL(cfg_sel6),
    .CFG_ADDR(cfg_addr6), .CFG_DATA(cfg_data6), .START(start6),
    .INIT_STATE(init_state6), .IN_VALID(in_valid6), .IN_READY(in_ready6),
    .IN_SYM(in_sym6), .FLUSH(flush6), .O_VALID(o_valid6), .O_READY(o_ready6),
    .O_BITS(o_bits6), .O_NB(o_nb6), .FINAL_STATE(final_state6),
    .FINAL_VALID(final_valid6), .BUSY(busy6), .ERR(err6)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the R=3 instance ----------------
  int ls_m[4];
  int st_m[4];
  int enc_m[8];
  int x_m = 8;
  bit err_m = 0, busy_m = 0, run_m = 0, flush_pend = 0;
  int q_nb[$], q_bits[$];
  int got_nb[$], got_bits[$];
  bit mon_en = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      bit was_busy;
      check("busy", busy, busy_m);
      check("err", err, err_m);
      check("o_valid", o_valid, q_nb.size() != 0);
      if (q_nb.size() != 0) begin
        check("o_nb", o_nb, q_nb[0]);
        check("o_bits", o_bits, q_bits[0]);
      end
      check("in_ready", in_ready, run_m && (q_nb.size() == 0 || o_ready));
      if (final_valid) begin
        check("final_expected", flush_pend, 1);
        check("final_drained", q_nb.size(), 0);
        check("final_state", final_state, x_m);
      end

      if (rst) begin
        x_m = 8; err_m = 0; busy_m = 0; run_m = 0; flush_pend = 0;
        q_nb.delete(); q_bits.delete();
      end else begin
        was_busy = busy_m;
        if (o_valid && o_ready && q_nb.size() != 0) begin
          got_nb.push_back(q_nb[0]);
          got_bits.push_back(q_bits[0]);
          void'(q_nb.pop_front());
          void'(q_bits.pop_front());
        end
        if (run_m && in_valid && in_ready) begin
          int ls, nb, idx;
          ls = ls_m[in_sym];
          if (ls == 0) err_m = 1;
          else begin
            nb = 3;
            for (int k = 0; k <= 3; k++)
              if ((x_m >> k) <= 2 * ls - 1) begin nb = k; break; end
            q_nb.push_back(nb);
            q_bits.push_back(x_m % (1 << nb));
            idx = st_m[in_sym] + (x_m >> nb) - ls;
            idx = ((idx % 8) + 8) % 8;
            x_m = enc_m[idx];
          end
        end
        if (run_m && flush) begin run_m = 0; flush_pend = 1; end
        if (final_valid) begin busy_m = 0; flush_pend = 0; end
        if (!was_busy && start) begin
          busy_m = 1; run_m = 1; err_m = 0;
          x_m = 8 | (init_state & 7);
        end
        if (!was_busy && cfg_we) begin
          case (cfg_sel)
            2'b00: ls_m[cfg_addr % 4] = cfg_data;
            2'b01: st_m[cfg_addr % 4] = cfg_data % 8;
            2'b10: enc_m[cfg_addr] = cfg_data;
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(int sel, int addr, int data);
    cfg_we = 1; cfg_sel = 2'(sel); cfg_addr = 3'(addr); cfg_data = 4'(data);
    tick();
    cfg_we = 0;
  endtask

  task automatic load_common();
    int lsv[4] = '{4, 2, 1, 1};
    int stv[4] = '{0, 4, 6, 7};
    for (int i = 0; i < 4; i++) cfg_write(0, i, lsv[i]);
    for (int i = 0; i < 4; i++) cfg_write(1, i, stv[i]);
    for (int i = 0; i < 8; i++) cfg_write(2, i, 8 + i);
  endtask

  task automatic start_block(int init);
    start = 1; init_state = 4'(init);
    tick();
    start = 0;
  endtask

  task automatic send_sym(int s);
    bit acc = 0;
    in_valid = 1; in_sym = 2'(s);
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk); acc = in_ready;
      tick();
    end
    in_valid = 0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic do_flush();
    flush = 1; tick(); flush = 0;
  endtask

  task automatic wait_final(string name, int exp_final);
    bit seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (final_valid) begin
        seen = 1;
        if (exp_final >= 0) check(name, final_state, exp_final);
      end
      tick();
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
    // FINAL_VALID must not repeat on the following cycle.
    @(negedge clk); check({name, "_single_pulse"}, final_valid, 0);
    tick();
  endtask

  task automatic check_s1_beats(string name);
    int enb[4] = '{1, 3, 2, 3};
    int ebt[4] = '{0, 0, 3, 5};
    check({name, "_nbeats"}, got_nb.size(), 4);
    for (int i = 0; i < 4 && i < got_nb.size(); i++) begin
      check($sformatf("%s_nb%0d", name, i), got_nb[i], enb[i]);
      check($sformatf("%s_bits%0d", name, i), got_bits[i], ebt[i]);
    end
  endtask

  task automatic clear_got();
    got_nb.delete(); got_bits.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; cfg_we = 0; cfg_sel = 0; cfg_addr = 0; cfg_data = 0;
    start = 0; init_state = 8; in_valid = 0; in_sym = 0; flush = 0;
    o_ready = 1;
    cfg_we6 = 0; cfg_sel6 = 0; cfg_addr6 = 0; cfg_data6 = 0; start6 = 0;
    init_state6 = 32; in_valid6 = 0; in_sym6 = 0; flush6 = 0; o_ready6 = 1;
    tick();
    mon_en = 1;
    tick(); tick();
    rst = 0;
    @(negedge clk);
    check("rst_o_bits", o_bits, 0);
    check("rst_o_nb", o_nb, 0);
    check("rst_final_state", final_state, 0);
    check("rst_final_valid", final_valid, 0);
    tick();

    // 1. basic sequence
    load_common();
    clear_got();
    start_block(8);
    send_sym(0); send_sym(3); send_sym(1); send_sym(2);
    do_flush();
    wait_final("s1_final", 14);
    check_s1_beats("s1");

    // 2. back-pressure after the first beat
    clear_got();
    start_block(8);
    send_sym(0);
    o_ready = 0; in_valid = 1; in_sym = 3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s2_stall_in_ready", in_ready, 0);
      check("s2_hold_valid", o_valid, 1);
      check("s2_hold_nb", o_nb, 1);
      check("s2_hold_bits", o_bits, 0);
      tick();
    end
    in_valid = 0; o_ready = 1;
    send_sym(3); send_sym(1); send_sym(2);
    do_flush();
    wait_final("s2_final", 14);
    check_s1_beats("s2");

    // 3. zero-count symbol
    cfg_write(0, 2, 0);
    clear_got();
    start_block(8);
    send_sym(0); send_sym(2);
    @(negedge clk); check("s3_err_set", err, 1); tick();
    send_sym(1);
    do_flush();
    wait_final("s3_final", 12);
    check("s3_nbeats", got_nb.size(), 2);
    if (got_nb.size() == 2) begin
      check("s3_nb1", got_nb[1], 2);
      check("s3_bits1", got_bits[1], 0);
    end
    @(negedge clk); check("s3_err_sticky", err, 1); tick();
    start_block(8);
    @(negedge clk); check("s3_err_cleared", err, 0); tick();
    do_flush();
    wait_final("s3_empty_final", 8);
    cfg_write(0, 2, 1);

    // 4. simultaneous events; ignored START and CFG_WE while busy
    clear_got();
    start_block(8);
    send_sym(0);
    start = 1; init_state = 3; tick(); start = 0;
    send_sym(3); send_sym(1);
    in_valid = 1; in_sym = 2; flush = 1; tick();
    in_valid = 0; flush = 0;
    start = 1; init_state = 3;
    cfg_we = 1; cfg_sel = 2; cfg_addr = 0; cfg_data = 15;
    tick();
    start = 0; cfg_we = 0;
    wait_final("s4_final", 14);
    check_s1_beats("s4");

    // 5. reset mid-block with a pending beat
    start_block(8);
    o_ready = 0;
    send_sym(0);
    @(negedge clk); check("s5_pending", o_valid, 1); tick();
    rst = 1; tick(); rst = 0;
    @(negedge clk);
    check("s5_o_valid", o_valid, 0);
    check("s5_o_bits", o_bits, 0);
    check("s5_o_nb", o_nb, 0);
    check("s5_final_state", final_state, 0);
    check("s5_final_valid", final_valid, 0);
    check("s5_busy", busy, 0);
    check("s5_err", err, 0);
    check("s5_in_ready", in_ready, 0);
    tick();
    o_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("s5_no_final", final_valid, 0); tick();
    end
    clear_got();
    start_block(8);
    send_sym(0); send_sym(3); send_sym(1); send_sym(2);
    do_flush();
    wait_final("s5_final", 14);
    check_s1_beats("s5");

    // randomized blocks against the model
    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < 4; i++) cfg_write(0, i, $urandom_range(0, 8));
      for (int i = 0; i < 4; i++) cfg_write(1, i, $urandom_range(0, 7));
      for (int i = 0; i < 8; i++) cfg_write(2, i, $urandom_range(8, 15));
      start_block($urandom_range(0, 15));
      for (int c = 0; c < 30; c++) begin
        in_valid = 1'($urandom_range(0, 3) != 0);
        in_sym = 2'($urandom_range(0, 3));
        o_ready = 1'($urandom_range(0, 9) < 7);
        start = 1'($urandom_range(0, 15) == 0);
        init_state = 4'($urandom_range(0, 15));
        cfg_we = 1'($urandom_range(0, 15) == 0);
        cfg_sel = 2'($urandom_range(0, 3));
        cfg_addr = 3'($urandom_range(0, 7));
        cfg_data = 4'($urandom_range(0, 15));
        tick();
      end
      start = 0; cfg_we = 0;
      in_valid = 1'($urandom_range(0, 1));
      in_sym = 2'($urandom_range(0, 3));
      flush = 1; tick(); flush = 0; in_valid = 0;
      for (int c = 0; c < 100 && busy_m; c++) begin
        o_ready = 1'($urandom_range(0, 2) != 0);
        tick();
      end
      check("rand_block_done", busy_m, 0);
      o_ready = 1;
    end

    // 6. wide configuration, uniform table
    begin
      int x6, s, enc_i;
      for (int i = 0; i < 8; i++) begin
        cfg_we6 = 1; cfg_sel6 = 0; cfg_addr6 = 5'(i); cfg_data6 = 4; tick();
        cfg_sel6 = 1; cfg_data6 = 6'(4 * i); tick();
      end
      for (int i = 0; i < 32; i++) begin
        cfg_sel6 = 2; cfg_addr6 = 5'(i); cfg_data6 = 6'(32 + i); tick();
      end
      cfg_we6 = 0;
      start6 = 1; init_state6 = 32; tick(); start6 = 0;
      x6 = 32;
      for (int i = 0; i < 12; i++) begin
        s = $urandom_range(0, 7);
        in_valid6 = 1; in_sym6 = 3'(s);
        @(negedge clk); check("s6_in_ready", in_ready6, 1);
        tick();
        in_valid6 = 0;
        @(negedge clk);
        check("s6_o_valid", o_valid6, 1);
        check("s6_o_nb", o_nb6, 3);
        check("s6_o_bits", o_bits6, x6 % 8);
        enc_i = (4 * s + x6 / 8 - 4) % 32;
        x6 = 32 + enc_i;
        tick();
      end
      flush6 = 1; tick(); flush6 = 0;
      begin
        bit seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(negedge clk);
          if (final_valid6) begin
            seen = 1;
            check("s6_final", final_state6, x6);
          end
          tick();
        end
        if (!seen) check("s6_final_timeout", 0, 1);
      end
      check("s6_err", err6, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
